// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and raster bundle types.
// Derived totals and sync windows live here so every stage agrees.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF = 4;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL =
    H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL =
    V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // END values are exclusive: sync is low for START <= pos < END
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic de;
    logic fs;
  } raster_flags_t;

  localparam raster_flags_t FLAGS_RST = '{
    h_sync: 1'b1,
    v_sync: 1'b1,
    de:     1'b1,
    fs:     1'b1
  };

endpackage

// File: rtl/vga_timing_core_pixel_tick_gen.sv
// Board-clock divider producing a one-cycle pixel-rate enable.
// The enable is decoded from the divider so it needs no extra flop.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic board_clk,
  input  logic reset,
  output logic pixel_en
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign pixel_en = (div == LAST);

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster counters with registered sync/visible/frame flags.
// Flags decode the next position so they line up with the counters.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       board_clk,
  input  logic       reset,
  output logic       pixel_en,
  output logic [9:0] counter_x,
  output logic [9:0] counter_y,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       in_display_area,
  output logic       frame_start
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSS = H_ACTIVE + H_FP;
  localparam int HSE = HSS + H_SYNC;
  localparam int VSS = V_ACTIVE + V_FP;
  localparam int VSE = VSS + V_SYNC;

  coord_t        x_next;
  coord_t        y_next;
  raster_flags_t flags;
  raster_flags_t flags_next;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .board_clk (board_clk),
    .reset     (reset),
    .pixel_en  (pixel_en)
  );

  always_comb begin
    x_next = counter_x + 10'd1;
    y_next = counter_y;
    if (counter_x == coord_t'(HT - 1)) begin
      x_next = '0;
      if (counter_y == coord_t'(VT - 1)) begin
        y_next = '0;
      end else begin
        y_next = counter_y + 10'd1;
      end
    end
  end

  always_comb begin
    flags_next.h_sync = !(x_next >= coord_t'(HSS) &&
                          x_next <  coord_t'(HSE));
    flags_next.v_sync = !(y_next >= coord_t'(VSS) &&
                          y_next <  coord_t'(VSE));
    flags_next.de     = (x_next < coord_t'(H_ACTIVE)) &&
                        (y_next < coord_t'(V_ACTIVE));
    flags_next.fs     = (x_next == '0) && (y_next == '0);
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      counter_x <= '0;
      counter_y <= '0;
      flags     <= FLAGS_RST;
    end else if (pixel_en) begin
      counter_x <= x_next;
      counter_y <= y_next;
      flags     <= flags_next;
    end
  end

  assign vga_h_sync      = flags.h_sync;
  assign vga_v_sync      = flags.v_sync;
  assign in_display_area = flags.de;
  assign frame_start     = flags.fs;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench: full-size core plus a shrunken raster for whole-frame runs,
// both checked every cycle against an edge-count arithmetic model.
module tb_vga_timing_core;

  localparam int B_DIV = 2;
  localparam int B_HA = 20, B_HFP = 3, B_HS = 5, B_HBP = 4;
  localparam int B_VA = 12, B_VFP = 2, B_VS = 2, B_VBP = 3;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;

  logic       en_a, hs_a, vs_a, de_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       en_b, hs_b, vs_b, de_b, fs_b;
  logic [9:0] x_b, y_b;

  int n;
  int checks = 0;
  int errors = 0;

  int hs_low_a, de_cnt_b, fs_cnt_b, vs_low_b;

  vga_timing_core dut_a (
    .board_clk       (board_clk),
    .reset           (reset),
    .pixel_en        (en_a),
    .counter_x       (x_a),
    .counter_y       (y_a),
    .vga_h_sync      (hs_a),
    .vga_v_sync      (vs_a),
    .in_display_area (de_a),
    .frame_start     (fs_a)
  );

  vga_timing_core #(
    .CLK_DIV (B_DIV),
    .H_ACTIVE (B_HA), .H_FP (B_HFP),
    .H_SYNC (B_HS), .H_BP (B_HBP),
    .V_ACTIVE (B_VA), .V_FP (B_VFP),
    .V_SYNC (B_VS), .V_BP (B_VBP)
  ) dut_b (
    .board_clk       (board_clk),
    .reset           (reset),
    .pixel_en        (en_b),
    .counter_x       (x_b),
    .counter_y       (y_b),
    .vga_h_sync      (hs_b),
    .vga_v_sync      (vs_b),
    .in_display_area (de_b),
    .frame_start     (fs_b)
  );

  always #5 board_clk = ~board_clk;

  // rising edges seen since reset was last released
  always @(posedge board_clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  function automatic logic [24:0] model(
    input int k, input int cd,
    input int ha, input int hfp, input int hs, input int hbp,
    input int va, input int vfp, input int vs, input int vbp
  );
    int ht, vt, p, x, y;
    logic en, h, v, de, fs;
    logic [9:0] xv, yv;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    p  = k / cd;
    x  = p % ht;
    y  = (p / ht) % vt;
    en = ((k % cd) == cd - 1);
    h  = !(x >= ha + hfp && x < ha + hfp + hs);
    v  = !(y >= va + vfp && y < va + vfp + vs);
    de = (x < ha) && (y < va);
    fs = (x == 0) && (y == 0);
    xv = 10'(x);
    yv = 10'(y);
    return {en, xv, yv, h, v, de, fs};
  endfunction

  function automatic logic [24:0] exp_a(input int k);
    return model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [24:0] exp_b(input int k);
    return model(k, B_DIV, B_HA, B_HFP, B_HS, B_HBP,
                 B_VA, B_VFP, B_VS, B_VBP);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge board_clk);
      check("cyc_a", 32'({en_a, x_a, y_a, hs_a, vs_a, de_a, fs_a}),
            32'(exp_a(n)));
      check("cyc_b", 32'({en_b, x_b, y_b, hs_b, vs_b, de_b, fs_b}),
            32'(exp_b(n)));
      if (en_a && y_a == 10'd0 && !hs_a) hs_low_a++;
      if (en_b && de_b) de_cnt_b++;
      if (en_b && fs_b) fs_cnt_b++;
      if (en_b && !vs_b) vs_low_b++;
    end
  endtask

  initial begin
    #12;
    check("rst_en", 32'(en_a), 32'd0);
    check("rst_x", 32'(x_a), 32'd0);
    check("rst_y", 32'(y_a), 32'd0);
    check("rst_hs", 32'(hs_a), 32'd1);
    check("rst_vs", 32'(vs_a), 32'd1);
    check("rst_de", 32'(de_a), 32'd1);
    check("rst_fs", 32'(fs_a), 32'd1);
    step(2);
    reset = 1'b0;
    hs_low_a = 0;
    de_cnt_b = 0;
    fs_cnt_b = 0;
    vs_low_b = 0;

    step(2);
    check("en_before_3rd", 32'(en_a), 32'd0);
    step(1);
    check("first_en", 32'(en_a), 32'd1);
    check("x_before_4th", 32'(x_a), 32'd0);
    step(1);
    check("x_on_4th", 32'(x_a), 32'd1);
    check("en_after_4th", 32'(en_a), 32'd0);
    check("b_x_on_4th", 32'(x_b), 32'd2);

    step(3200 - 4);
    check("a_line_wrap_x", 32'(x_a), 32'd0);
    check("a_line_wrap_y", 32'(y_a), 32'd1);

    step(3 * B_HT * B_VT * B_DIV - 3200);
    check("a_hs_low_len", 32'(hs_low_a), 32'd96);
    check("b_frame_cnt", 32'(fs_cnt_b), 32'd3);
    check("b_de_cnt", 32'(de_cnt_b), 32'(3 * B_HA * B_VA));
    check("b_vs_low", 32'(vs_low_b), 32'(3 * B_VS * B_HT));
    check("b_frame_wrap_x", 32'(x_b), 32'd0);
    check("b_frame_wrap_y", 32'(y_b), 32'd0);

    // random mid-frame resets, asserted before or after an edge
    repeat (6) begin
      step($urandom_range(50, 2500));
      #($urandom_range(1, 8));
      reset = 1'b1;
      #1;
      check("async_rst_a",
            32'({en_a, x_a, y_a, hs_a, vs_a, de_a, fs_a}),
            32'(exp_a(0)));
      check("async_rst_b",
            32'({en_b, x_b, y_b, hs_b, vs_b, de_b, fs_b}),
            32'(exp_b(0)));
      step($urandom_range(1, 4));
      reset = 1'b0;
      step(B_DIV * B_HT * 2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
